// File: rtl/montgomery_pkg.sv
// Shared constants and FSM encoding for the modular add/sub stage.
// The internal datapath is padded to a whole number of adder chunks.
package montgomery_pkg;
    localparam int WIDTH      = 1027;
    localparam int ADDER_SIZE = 257;
    // ceil((WIDTH+1)/ADDER_SIZE): one spare bit keeps the raw sum/difference exact
    localparam int CYCLE      = (WIDTH + ADDER_SIZE) / ADDER_SIZE;
    localparam int PAD_W      = CYCLE * ADDER_SIZE;
    localparam int CNT_W      = $clog2(CYCLE) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        SEL  = 2'd3
    } state_t;
endpackage

// File: rtl/mod_add_sub_if.sv
// Request/response bundle of the modular add/sub stage.
// The requester drives operands and start; the stage returns result, busy and done.
interface mod_add_sub_if;
    import montgomery_pkg::*;

    logic             start;
    logic             subtract;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_m;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, subtract, in_a, in_b, in_m,
        input  result, busy, done
    );

    modport slave (
        input  start, subtract, in_a, in_b, in_m,
        output result, busy, done
    );
endinterface

// File: rtl/mp_chunk_adder.sv
// One ADDER_SIZE-bit adder slice: {cout,sum} = a + (inv ? ~b : b) + cin.
// Purely combinational; the caller registers the carry between chunks.
module mp_chunk_adder
    import montgomery_pkg::*;
(
    input  logic [ADDER_SIZE-1:0] a,
    input  logic [ADDER_SIZE-1:0] b,
    input  logic                  inv,
    input  logic                  cin,
    output logic [ADDER_SIZE-1:0] sum,
    output logic                  cout
);
    logic [ADDER_SIZE-1:0] b_eff;

    assign b_eff       = inv ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{ADDER_SIZE{1'b0}}, cin};
endmodule

// File: rtl/mod_add_sub.sv
// Constant-time (a+b) mod m / (a-b) mod m using two chunked passes through one adder.
// Pass 1 forms the raw sum/difference S, pass 2 the m-corrected T; carries pick the result.
module mod_add_sub
    import montgomery_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mod_add_sub_if.slave bus
);
    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic [PAD_W-1:0]      a_reg, b_reg, m_reg, s_reg, t_reg;
    logic                  sub_reg, carry_reg, c1_reg, c2_reg, done_reg;
    logic [WIDTH-1:0]      result_reg;

    logic [ADDER_SIZE-1:0] add_x, add_y, add_sum;
    logic                  add_inv, add_cin, add_cout;
    logic                  last_chunk;

    assign last_chunk = (cnt_reg == CNT_W'(CYCLE - 1));

    // Pass 2 inverts m only in add mode, so the first-chunk carry equals the invert flag.
    always_comb begin
        add_x   = a_reg[ADDER_SIZE-1:0];
        add_y   = b_reg[ADDER_SIZE-1:0];
        add_inv = sub_reg;
        if (state_reg == P2) begin
            add_x   = s_reg[ADDER_SIZE-1:0];
            add_y   = m_reg[ADDER_SIZE-1:0];
            add_inv = !sub_reg;
        end
        add_cin = (cnt_reg == CNT_W'(0)) ? add_inv : carry_reg;
    end

    mp_chunk_adder u_adder (
        .a    (add_x),
        .b    (add_y),
        .inv  (add_inv),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = P1;
            P1:      if (last_chunk) state_next = P2;
            P2:      if (last_chunk) state_next = SEL;
            SEL:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            m_reg      <= '0;
            s_reg      <= '0;
            t_reg      <= '0;
            sub_reg    <= 1'b0;
            carry_reg  <= 1'b0;
            c1_reg     <= 1'b0;
            c2_reg     <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    cnt_reg  <= '0;
                    if (bus.start) begin
                        a_reg   <= PAD_W'(bus.in_a);
                        b_reg   <= PAD_W'(bus.in_b);
                        m_reg   <= PAD_W'(bus.in_m);
                        sub_reg <= bus.subtract;
                    end
                end
                P1: begin
                    s_reg     <= {add_sum, s_reg[PAD_W-1:ADDER_SIZE]};
                    a_reg     <= a_reg >> ADDER_SIZE;
                    b_reg     <= b_reg >> ADDER_SIZE;
                    carry_reg <= add_cout;
                    cnt_reg   <= last_chunk ? '0 : cnt_reg + CNT_W'(1);
                    if (last_chunk) c1_reg <= add_cout;
                end
                P2: begin
                    // S is rotated, not shifted, so it is intact again after CYCLE chunks
                    s_reg     <= {s_reg[ADDER_SIZE-1:0], s_reg[PAD_W-1:ADDER_SIZE]};
                    t_reg     <= {add_sum, t_reg[PAD_W-1:ADDER_SIZE]};
                    m_reg     <= m_reg >> ADDER_SIZE;
                    carry_reg <= add_cout;
                    cnt_reg   <= last_chunk ? '0 : cnt_reg + CNT_W'(1);
                    if (last_chunk) c2_reg <= add_cout;
                end
                SEL: begin
                    done_reg <= 1'b1;
                    if (sub_reg) begin
                        result_reg <= c1_reg ? s_reg[WIDTH-1:0] : t_reg[WIDTH-1:0];
                    end else begin
                        result_reg <= c2_reg ? t_reg[WIDTH-1:0] : s_reg[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state_reg != IDLE);
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
endmodule

// File: tb/tb_mod_add_sub.sv
// Directed and small randomised checks of mod_add_sub against hand values and a big-integer model.
module tb_mod_add_sub;
    import montgomery_pkg::*;

    localparam int CHK_W = WIDTH + 1;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    mod_add_sub_if bus ();

    mod_add_sub dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [CHK_W-1:0] got, input logic [CHK_W-1:0] exp);
        logic [127:0] got_lo, exp_lo;
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            got_lo = got[127:0];
            exp_lo = exp[127:0];
            $display("FAIL %s: got(low128)=%h expected(low128)=%h", tag, got_lo, exp_lo);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_big();
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < (WIDTH + 31) / 32; i++) v = (v << 32) | WIDTH'($urandom);
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] model(input logic sub, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        if (!sub) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, m}) s = s - {1'b0, m};
        end else if (a >= b) begin
            s = {1'b0, a} - {1'b0, b};
        end else begin
            s = {1'b0, a} + {1'b0, m} - {1'b0, b};
        end
        return s[WIDTH-1:0];
    endfunction

    // Called at a negedge with the DUT idle (or in its done cycle); returns at the negedge of done.
    task automatic run_op(input logic sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] m, input int poke_at,
                          output logic [WIDTH-1:0] res, output int lat, output int busy_cnt,
                          output logic held);
        logic [WIDTH-1:0] entry;
        entry        = bus.result;
        held         = 1'b1;
        bus.subtract = sub;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_m     = m;
        bus.start    = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        bus.subtract = ~sub;
        busy_cnt     = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            if (bus.result !== entry) held = 1'b0;
            bus.start = (lat == poke_at);
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.start = 1'b0;
            if (!bus.done && bus.busy) busy_cnt++;
        end
        res = bus.result;
    endtask

    initial begin
        logic [WIDTH-1:0] res, mbig, m, a, b;
        int               lat, busy_cnt, done_seen;
        logic             held, sub;

        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.subtract = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_m     = '0;
        repeat (3) @(negedge clk);
        check("reset_result", CHK_W'(bus.result), '0);
        check("reset_busy", CHK_W'(bus.busy), '0);
        check("reset_done", CHK_W'(bus.done), '0);
        reset = 1'b0;
        @(negedge clk);

        run_op(1'b0, 5, 7, 11, -1, res, lat, busy_cnt, held);
        $display("[TB] add 5+7 mod 11 -> %0d lat=%0d busy=%0d", res[31:0], lat, busy_cnt);
        check("add_5_7", CHK_W'(res), 1);
        check("latency", CHK_W'(lat), 10);
        check("busy_cycles", CHK_W'(busy_cnt), 9);
        check("busy_in_done", CHK_W'(bus.busy), 0);
        @(negedge clk);
        check("done_pulse", CHK_W'(bus.done), 0);

        run_op(1'b0, 3, 4, 11, -1, res, lat, busy_cnt, held);
        $display("[TB] add 3+4 mod 11 -> %0d", res[31:0]);
        check("add_3_4", CHK_W'(res), 7);
        @(negedge clk);
        run_op(1'b1, 7, 3, 11, -1, res, lat, busy_cnt, held);
        $display("[TB] sub 7-3 mod 11 -> %0d", res[31:0]);
        check("sub_7_3", CHK_W'(res), 4);
        @(negedge clk);
        run_op(1'b1, 3, 7, 11, -1, res, lat, busy_cnt, held);
        $display("[TB] sub 3-7 mod 11 -> %0d", res[31:0]);
        check("sub_3_7", CHK_W'(res), 7);
        @(negedge clk);

        mbig = '1;
        run_op(1'b0, mbig - 1, mbig - 1, mbig, -1, res, lat, busy_cnt, held);
        $display("[TB] add big (m-1)+(m-1) lat=%0d", lat);
        check("add_big", CHK_W'(res), CHK_W'(mbig - 2));
        @(negedge clk);
        run_op(1'b1, 0, 1, mbig, -1, res, lat, busy_cnt, held);
        $display("[TB] sub big 0-1 lat=%0d", lat);
        check("sub_big", CHK_W'(res), CHK_W'(mbig - 1));
        @(negedge clk);

        // back-to-back: second request issued in the done cycle of the first
        run_op(1'b0, 5, 7, 11, -1, res, lat, busy_cnt, held);
        check("b2b_first", CHK_W'(res), 1);
        run_op(1'b0, 1, 1, 11, -1, res, lat, busy_cnt, held);
        $display("[TB] back-to-back 1+1 mod 11 -> %0d lat=%0d held=%0d", res[31:0], lat, held);
        check("b2b_second", CHK_W'(res), 2);
        check("b2b_latency", CHK_W'(lat), 10);
        check("b2b_held", CHK_W'(held), 1);
        @(negedge clk);

        run_op(1'b0, 3, 4, 11, 2, res, lat, busy_cnt, held);
        $display("[TB] start pulsed in P1 -> %0d lat=%0d", res[31:0], lat);
        check("ignore_start_res", CHK_W'(res), 7);
        check("ignore_start_lat", CHK_W'(lat), 10);
        repeat (3) @(negedge clk);
        check("ignore_start_idle", CHK_W'(bus.busy), 0);

        // reset while in pass 2
        bus.subtract = 1'b0;
        bus.in_a     = 5;
        bus.in_b     = 7;
        bus.in_m     = 11;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_result", CHK_W'(bus.result), 0);
        check("midrst_busy", CHK_W'(bus.busy), 0);
        check("midrst_done", CHK_W'(bus.done), 0);
        @(negedge clk);
        reset     = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        $display("[TB] reset in P2: done pulses afterwards=%0d", done_seen);
        check("midrst_no_done", CHK_W'(done_seen), 0);
        run_op(1'b1, 3, 7, 11, -1, res, lat, busy_cnt, held);
        $display("[TB] after reset sub 3-7 mod 11 -> %0d", res[31:0]);
        check("after_rst", CHK_W'(res), 7);
        @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            m = rand_big();
            if (i % 2 == 1) m = m & WIDTH'(32'hFFFF_FFFF);
            m   = m | WIDTH'(3);
            a   = rand_big() % m;
            b   = rand_big() % m;
            sub = i[2];
            run_op(sub, a, b, m, -1, res, lat, busy_cnt, held);
            $display("[TB] rand %0d sub=%0d res(low32)=%h lat=%0d", i, sub, res[31:0], lat);
            check("rand_result", CHK_W'(res), CHK_W'(model(sub, a, b, m)));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
